// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage decode, load-use hazard detection and ID/EX
// control register for a 5-stage RISC-V-style pipeline.
// Optional build macro ID_ILLEGAL_TRAP_EN: when defined, an illegal valid
// instruction enters EX as a marked bubble (valid_e=1, illegal_e=1).
module id_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        pc_src_e,
  output logic [1:0]  imm_src_d,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        reg_write_e,
  output logic        mem_read_e,
  output logic        mem_write_e,
  output logic        alu_src_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic        jalr_e,
  output logic [4:0]  rd_e,
  output logic        valid_e,
  output logic        illegal_e,
  output logic [15:0] stall_cnt
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_JALR   = 7'b1100111,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
    logic jalr;
  } ctrl_t;

  ctrl_t       ctrl_d, ctrl_q;
  imm_e        imm_d;
  logic        rs1_used, rs2_used, legal_d;
  logic [4:0]  rs1, rs2;
  logic [4:0]  rd_q;
  logic        valid_q;
  logic [15:0] cnt_q;
  logic [15:0] stall_cnt_q;
  logic        hazard, stall;

  // Function bits and upper immediate bits are consumed elsewhere.
  logic unused_bits;
  assign unused_bits = ^{instr_d[31:25], instr_d[14:12]};

  assign rs1 = instr_d[19:15];
  assign rs2 = instr_d[24:20];

  // Opcode decode; an empty IF/ID slot decodes as an illegal-free no-op.
  always_comb begin
    ctrl_d   = '0;
    imm_d    = IMM_I;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    legal_d  = 1'b1;
    case (instr_d[6:0])
      OPC_LOAD: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.mem_read = 1'b1; ctrl_d.alu_src = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_JALR: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.jalr = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_STORE: begin
        ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1;
        imm_d = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_d.branch = 1'b1;
        imm_d = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_JAL: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1;
        imm_d = IMM_J;
      end
      OPC_OP: begin
        ctrl_d.reg_write = 1'b1;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      default: legal_d = 1'b0;
    endcase
    if (!valid_d) begin
      ctrl_d   = '0;
      imm_d    = IMM_I;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      legal_d  = 1'b1;
    end
  end

  // rd_q is already zero for non-writing instructions, so rd!=0 implies a write.
  assign hazard = valid_d & valid_q & ctrl_q.mem_read & (rd_q != 5'd0) &
                  ((rs1_used & (rs1 == rd_q)) | (rs2_used & (rs2 == rd_q)));

  // Gating with rst keeps the hazard outputs quiet while state is being reset.
  assign stall     = hazard & ~pc_src_e & ~rst;
  assign stall_f   = stall;
  assign stall_d   = stall;
  assign flush_d   = pc_src_e & ~rst;
  assign imm_src_d = imm_d;

  // Saturating count of load-use stall cycles.
  always_comb begin
    cnt_q = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) cnt_q = stall_cnt_q + 16'd1;
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_e = illegal_q;
`else
  assign illegal_e = 1'b0;
`endif

  // ID/EX register: bubble on reset, redirect, hazard or empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      rd_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      stall_cnt_q <= cnt_q;
      ctrl_q      <= '0;
      rd_q        <= '0;
      valid_q     <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
      if (!pc_src_e && !hazard && valid_d) begin
        if (legal_d) begin
          ctrl_q  <= ctrl_d;
          rd_q    <= ctrl_d.reg_write ? instr_d[11:7] : 5'd0;
          valid_q <= 1'b1;
        end else begin
`ifdef ID_ILLEGAL_TRAP_EN
          valid_q   <= 1'b1;
          illegal_q <= 1'b1;
`endif
        end
      end
    end
  end

  assign reg_write_e = ctrl_q.reg_write;
  assign mem_read_e  = ctrl_q.mem_read;
  assign mem_write_e = ctrl_q.mem_write;
  assign alu_src_e   = ctrl_q.alu_src;
  assign branch_e    = ctrl_q.branch;
  assign jump_e      = ctrl_q.jump;
  assign jalr_e      = ctrl_q.jalr;
  assign rd_e        = rd_q;
  assign valid_e     = valid_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed scoreboard bench for id_hazard_ctrl.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, valid_d, pc_src_e;
  logic [31:0] instr_d;
  logic [1:0]  imm_src_d;
  logic        stall_f, stall_d, flush_d;
  logic        reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e;
  logic [4:0]  rd_e;
  logic        valid_e, illegal_e;
  logic [15:0] stall_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    logic [6:0]  ctl;
    logic [4:0]  rd;
    logic        valid;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference ID/EX state
  logic [6:0]  m_ctl = '0;
  logic [4:0]  m_rd = '0;
  logic        m_valid = 1'b0;
  logic        m_ill = 1'b0;
  logic [15:0] m_cnt = '0;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_src_e(pc_src_e),
    .imm_src_d(imm_src_d), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
    .rd_e(rd_e), .valid_e(valid_e), .illegal_e(illegal_e), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctl bit order: reg_write, mem_read, mem_write, alu_src, branch, jump, jalr
  function automatic void dec(input logic [31:0] ins, input logic v, output logic [6:0] ctl,
                              output logic [1:0] imm, output logic u1, output logic u2,
                              output logic legal);
    ctl = '0; imm = 2'b00; u1 = 1'b0; u2 = 1'b0; legal = 1'b1;
    case (ins[6:0])
      7'h03: begin ctl = 7'b1101000; u1 = 1'b1; end
      7'h13: begin ctl = 7'b1001000; u1 = 1'b1; end
      7'h67: begin ctl = 7'b1000011; u1 = 1'b1; end
      7'h23: begin ctl = 7'b0011000; imm = 2'b01; u1 = 1'b1; u2 = 1'b1; end
      7'h63: begin ctl = 7'b0000100; imm = 2'b10; u1 = 1'b1; u2 = 1'b1; end
      7'h6F: begin ctl = 7'b1000010; imm = 2'b11; end
      7'h33: begin ctl = 7'b1000000; u1 = 1'b1; u2 = 1'b1; end
      default: legal = 1'b0;
    endcase
    if (!v) begin
      ctl = '0; imm = 2'b00; u1 = 1'b0; u2 = 1'b0; legal = 1'b1;
    end
  endfunction

  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic pc, input logic r);
    logic [6:0] ctl;
    logic [1:0] imm;
    logic       u1, u2, legal, haz, stl;
    exp_t       e, got;
    instr_d = ins; valid_d = v; pc_src_e = pc; rst = r;
    #1;
    dec(ins, v, ctl, imm, u1, u2, legal);
    haz = v && m_valid && m_ctl[5] && (m_rd != 5'd0) &&
          ((u1 && ins[19:15] == m_rd) || (u2 && ins[24:20] == m_rd));
    stl = haz && !pc && !r;
    check({tag, ".imm_src_d"}, 32'(imm_src_d), 32'(imm));
    check({tag, ".stall_f"}, 32'(stall_f), 32'(stl));
    check({tag, ".stall_d"}, 32'(stall_d), 32'(stl));
    check({tag, ".flush_d"}, 32'(flush_d), 32'(pc && !r));
    e = '{ctl: '0, rd: '0, valid: 1'b0, ill: 1'b0, cnt: m_cnt};
    if (r) e.cnt = '0;
    else begin
      if (stl && m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
      if (!pc && !haz && v) begin
        if (legal) begin
          e.ctl = ctl; e.valid = 1'b1;
          e.rd = ctl[6] ? ins[11:7] : 5'd0;
        end else begin
`ifdef ID_ILLEGAL_TRAP_EN
          e.valid = 1'b1; e.ill = 1'b1;
`endif
        end
      end
    end
    q.push_back(e);
    m_ctl = e.ctl; m_rd = e.rd; m_valid = e.valid; m_ill = e.ill; m_cnt = e.cnt;
    @(posedge clk);
    #1;
    got = q.pop_front();
    check({tag, ".ctl_e"}, 32'({reg_write_e, mem_read_e, mem_write_e, alu_src_e,
                                branch_e, jump_e, jalr_e}), 32'(got.ctl));
    check({tag, ".rd_e"}, 32'(rd_e), 32'(got.rd));
    check({tag, ".valid_e"}, 32'(valid_e), 32'(got.valid));
    check({tag, ".illegal_e"}, 32'(illegal_e), 32'(got.ill));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(got.cnt));
    @(negedge clk);
  endtask

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_DEP = 32'h00728333;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_X0  = 32'h00700333;
  localparam logic [31:0] SW      = 32'h0062A023;
  localparam logic [31:0] JAL     = 32'h0000006F;
  localparam logic [31:0] LW_X6   = 32'h0000A303;
  localparam logic [31:0] BEQ     = 32'h00628063;
  localparam logic [31:0] JALR    = 32'h000280E7;
  localparam logic [31:0] ADDI    = 32'h00110093;
  localparam logic [31:0] LW_CHN  = 32'h0002A283;

  initial begin
    rst = 1'b1; valid_d = 1'b0; pc_src_e = 1'b0; instr_d = '0;
    @(negedge clk);
    step("rst0", LW_X5, 1'b1, 1'b1, 1'b1);
    step("rst1", '0, 1'b0, 1'b0, 1'b1);
    // load-use on rs1/rs2 of OP
    step("lw_x5", LW_X5, 1'b1, 1'b0, 1'b0);
    step("add_stall", ADD_DEP, 1'b1, 1'b0, 1'b0);
    step("add_go", ADD_DEP, 1'b1, 1'b0, 1'b0);
    // rd=x0 never hazards
    step("lw_x0", LW_X0, 1'b1, 1'b0, 1'b0);
    step("add_x0", ADD_X0, 1'b1, 1'b0, 1'b0);
    step("sw", SW, 1'b1, 1'b0, 1'b0);
    // redirect has priority over hazard
    step("lw_x5b", LW_X5, 1'b1, 1'b0, 1'b0);
    step("jal_flush", JAL, 1'b1, 1'b1, 1'b0);
    step("lw_x5c", LW_X5, 1'b1, 1'b0, 1'b0);
    step("add_flush", ADD_DEP, 1'b1, 1'b1, 1'b0);
    step("illegal", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    // rs2 hazard through branch, then other formats
    step("lw_x6", LW_X6, 1'b1, 1'b0, 1'b0);
    step("beq_stall", BEQ, 1'b1, 1'b0, 1'b0);
    step("beq_go", BEQ, 1'b1, 1'b0, 1'b0);
    step("jalr", JALR, 1'b1, 1'b0, 1'b0);
    step("addi", ADDI, 1'b1, 1'b0, 1'b0);
    // empty slot never stalls
    step("lw_x5d", LW_X5, 1'b1, 1'b0, 1'b0);
    step("invalid_dep", ADD_DEP, 1'b0, 1'b0, 1'b0);
    step("jal_nofl", JAL, 1'b1, 1'b0, 1'b0);
    // saturation: preload counter near its limit
    valid_d = 1'b0; pc_src_e = 1'b0; rst = 1'b0;
    force dut.stall_cnt_q = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.stall_cnt_q;
    m_ctl = '0; m_rd = '0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = 16'hFFFD;
    for (int i = 0; i < 7; i++) step("sat", LW_CHN, 1'b1, 1'b0, 1'b0);
    check("sat_final", 32'(stall_cnt), 32'h0000FFFF);
    // reset during a stall
    step("lw_x5e", LW_X5, 1'b1, 1'b0, 1'b0);
    step("rst_mid", ADD_DEP, 1'b1, 1'b0, 1'b1);
    step("post_rst", ADD_DEP, 1'b1, 1'b0, 1'b0);
    check("rst_cnt", 32'(stall_cnt), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
